// File: rtl/move_sequencer.sv
// Othello per-move controller: sweeps 8 directions via the validator, then flips and places.
// Define MOVE_SEQ_FLIP_COUNT_EN to build the saturating flip counter on flip_count_o.
module move_sequencer #(
    parameter int unsigned BOARD_W = 10,
    parameter int unsigned ADDR_W  = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              player,
    input  logic [ADDR_W-1:0] move_addr,
    input  logic              s_done_in,
    input  logic              dir_status_in,
    input  logic [1:0]        mem_data_in,
    output logic              ld_vali_o,
    output logic              start_vali_o,
    output logic [ADDR_W-1:0] step_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic              ctrl_mem_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_wren_o,
    output logic [1:0]        mem_data_o,
    output logic [7:0]        dir_mask_o,
    output logic              legal_o,
    output logic              done_o,
    output logic [5:0]        flip_count_o
);

    typedef enum logic [3:0] {
        StIdle, StLoad, StLaunch, StWait, StDecide, StFrd, StFchk, StFwr, StPlace, StDone
    } state_e;

    state_e     state_q;
    logic [2:0] idx_q;
    logic [2:0] walk_q;
    logic [1:0] colour_q;
    logic [2:0] first_idx;
    logic [2:0] next_idx;
    logic       next_found;
    logic       flip_wr;

    function automatic logic [ADDR_W-1:0] dir_step(input logic [2:0] idx);
        logic [ADDR_W-1:0] w;
        w = ADDR_W'(BOARD_W);
        case (idx)
            3'd0:    dir_step = ADDR_W'(0) - w - ADDR_W'(1);
            3'd1:    dir_step = ADDR_W'(0) - w;
            3'd2:    dir_step = ADDR_W'(0) - w + ADDR_W'(1);
            3'd3:    dir_step = ADDR_W'(0) - ADDR_W'(1);
            3'd4:    dir_step = ADDR_W'(1);
            3'd5:    dir_step = w - ADDR_W'(1);
            3'd6:    dir_step = w;
            default: dir_step = w + ADDR_W'(1);
        endcase
    endfunction

    // Lowest set mask bit overall, and lowest set bit above the direction being walked.
    always_comb begin
        first_idx  = 3'd0;
        next_idx   = 3'd0;
        next_found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (dir_mask_o[i]) begin
                first_idx = 3'(i);
            end
            if (dir_mask_o[i] && (3'(i) > idx_q)) begin
                next_idx   = 3'(i);
                next_found = 1'b1;
            end
        end
    end

    // Walk is capped at 7 flips so a corrupt board cannot loop forever.
    assign flip_wr = (state_q == StFchk) && (mem_data_in == ~colour_q) && (walk_q != 3'd7);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            idx_q        <= 3'd0;
            walk_q       <= 3'd0;
            colour_q     <= 2'b00;
            ld_vali_o    <= 1'b0;
            start_vali_o <= 1'b0;
            step_o       <= '0;
            s_addr_o     <= '0;
            ctrl_mem_o   <= 1'b0;
            mem_addr_o   <= '0;
            mem_wren_o   <= 1'b0;
            mem_data_o   <= 2'b00;
            dir_mask_o   <= 8'd0;
            legal_o      <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            ld_vali_o <= 1'b0;
            done_o    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        colour_q   <= player ? 2'b10 : 2'b01;
                        s_addr_o   <= move_addr;
                        dir_mask_o <= 8'd0;
                        legal_o    <= 1'b0;
                        idx_q      <= 3'd0;
                        ld_vali_o  <= 1'b1;
                        step_o     <= dir_step(3'd0);
                        state_q    <= StLoad;
                    end
                end
                StLoad: begin
                    start_vali_o <= 1'b1;
                    state_q      <= StLaunch;
                end
                StLaunch: state_q <= StWait;
                StWait: begin
                    if (s_done_in) begin
                        dir_mask_o[idx_q] <= dir_status_in;
                        start_vali_o      <= 1'b0;
                        if (idx_q == 3'd7) begin
                            state_q <= StDecide;
                        end else begin
                            idx_q     <= idx_q + 3'd1;
                            ld_vali_o <= 1'b1;
                            step_o    <= dir_step(idx_q + 3'd1);
                            state_q   <= StLoad;
                        end
                    end
                end
                StDecide: begin
                    if (dir_mask_o == 8'd0) begin
                        legal_o <= 1'b0;
                        done_o  <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        idx_q      <= first_idx;
                        mem_addr_o <= s_addr_o + dir_step(first_idx);
                        ctrl_mem_o <= 1'b1;
                        walk_q     <= 3'd0;
                        state_q    <= StFrd;
                    end
                end
                StFrd: state_q <= StFchk;
                StFchk: begin
                    if (flip_wr) begin
                        mem_wren_o <= 1'b1;
                        mem_data_o <= colour_q;
                        walk_q     <= walk_q + 3'd1;
                        state_q    <= StFwr;
                    end else if (next_found) begin
                        idx_q      <= next_idx;
                        mem_addr_o <= s_addr_o + dir_step(next_idx);
                        walk_q     <= 3'd0;
                        state_q    <= StFrd;
                    end else begin
                        mem_addr_o <= s_addr_o;
                        mem_wren_o <= 1'b1;
                        mem_data_o <= colour_q;
                        state_q    <= StPlace;
                    end
                end
                StFwr: begin
                    mem_wren_o <= 1'b0;
                    mem_addr_o <= mem_addr_o + dir_step(idx_q);
                    state_q    <= StFrd;
                end
                StPlace: begin
                    mem_wren_o <= 1'b0;
                    mem_addr_o <= '0;
                    mem_data_o <= 2'b00;
                    ctrl_mem_o <= 1'b0;
                    legal_o    <= 1'b1;
                    done_o     <= 1'b1;
                    state_q    <= StDone;
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef MOVE_SEQ_FLIP_COUNT_EN
    logic [5:0] flips_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flips_q <= 6'd0;
        end else if (start && (state_q == StIdle)) begin
            flips_q <= 6'd0;
        end else if (flip_wr && (flips_q != 6'd63)) begin
            flips_q <= flips_q + 6'd1;
        end
    end

    assign flip_count_o = flips_q;
`else
    assign flip_count_o = 6'd0;
`endif

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: board RAM and validator models plus an Othello reference model.
module tb_move_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       player = 1'b0;
    logic [6:0] move_addr = 7'd0;
    logic       s_done_in;
    logic       dir_status_in;
    logic [1:0] mem_data_in;
    logic       ld_vali_o, start_vali_o, ctrl_mem_o, mem_wren_o, legal_o, done_o;
    logic [6:0] step_o, s_addr_o, mem_addr_o;
    logic [1:0] mem_data_o;
    logic [7:0] dir_mask_o;
    logic [5:0] flip_count_o;

    move_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .player       (player),
        .move_addr    (move_addr),
        .s_done_in    (s_done_in),
        .dir_status_in(dir_status_in),
        .mem_data_in  (mem_data_in),
        .ld_vali_o    (ld_vali_o),
        .start_vali_o (start_vali_o),
        .step_o       (step_o),
        .s_addr_o     (s_addr_o),
        .ctrl_mem_o   (ctrl_mem_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wren_o   (mem_wren_o),
        .mem_data_o   (mem_data_o),
        .dir_mask_o   (dir_mask_o),
        .legal_o      (legal_o),
        .done_o       (done_o),
        .flip_count_o (flip_count_o)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int dir_tab [8] = '{117, 118, 119, 127, 1, 9, 10, 11};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Stimulus board (reference) and the RAM copy the DUT actually sees.
    logic [1:0] board [128];
    logic [1:0] mem [128];
    logic       ld_board = 1'b0;
    logic [8:0] wr_log [$];
    logic [6:0] step_log [$];
    bit         overlap = 1'b0;

    always @(posedge clock) begin
        if (ld_board) begin
            mem <= board;
        end else if (ctrl_mem_o && mem_wren_o) begin
            mem[mem_addr_o] <= mem_data_o;
            wr_log.push_back({mem_addr_o, mem_data_o});
        end
        mem_data_in <= mem[mem_addr_o];
        if (ld_vali_o) step_log.push_back(step_o);
        if (ld_vali_o && start_vali_o) overlap = 1'b1;
    end

    // Flips a move would make in one direction under Othello rules; 0 if the direction fails.
    function automatic int ref_run(input int addr, input int st, input logic [1:0] me);
        int p;
        int k;
        p = (addr + st) % 128;
        k = 0;
        while (board[p] == ~me && k < 8) begin
            k++;
            p = (p + st) % 128;
        end
        return (k > 0 && board[p] == me) ? k : 0;
    endfunction

    logic [6:0] v_step;
    int         v_cnt;
    bit         v_armed;
    int         v_delay = 1;
    bit         v_zero = 1'b0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            s_done_in     <= 1'b0;
            dir_status_in <= 1'b0;
            v_armed       <= 1'b0;
            v_cnt         <= 0;
        end else begin
            s_done_in <= 1'b0;
            if (ld_vali_o) begin
                v_step  <= step_o;
                v_armed <= 1'b1;
                v_cnt   <= 0;
            end else if (v_armed && start_vali_o) begin
                if (v_cnt + 1 >= v_delay) begin
                    s_done_in     <= 1'b1;
                    dir_status_in <= !v_zero &&
                        (ref_run(int'(s_addr_o), int'(v_step), player ? 2'b10 : 2'b01) > 0);
                    v_armed       <= 1'b0;
                end else begin
                    v_cnt <= v_cnt + 1;
                end
            end
        end
    end

    task automatic clear_board();
        for (int a = 0; a < 128; a++) begin
            if (a >= 100 || a / 10 == 0 || a / 10 == 9 || a % 10 == 0 || a % 10 == 9)
                board[a] = 2'b11;
            else
                board[a] = 2'b00;
        end
    endtask

    task automatic load_board();
        @(negedge clock);
        ld_board = 1'b1;
        @(negedge clock);
        ld_board = 1'b0;
    endtask

    task automatic run_move(input logic pl, input int addr, input int delay, input bit zero,
                            input bit glitch, input string tag);
        logic [1:0] me;
        logic [1:0] exp_b [128];
        logic [7:0] emask;
        int         flips, total, n, bad, exp_fc;
        me    = pl ? 2'b10 : 2'b01;
        exp_b = board;
        emask = 8'd0;
        total = 0;
        for (int d = 0; d < 8; d++) begin
            flips = zero ? 0 : ref_run(addr, dir_tab[d], me);
            if (flips > 0) begin
                emask[d] = 1'b1;
                total += flips;
                for (int k = 1; k <= flips; k++) exp_b[(addr + k * dir_tab[d]) % 128] = me;
            end
        end
        if (emask != 8'd0) exp_b[addr] = me;
        load_board();
        wr_log.delete();
        step_log.delete();
        overlap   = 1'b0;
        v_delay   = delay;
        v_zero    = zero;
        player    = pl;
        move_addr = 7'(addr);
        start     = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
            start = glitch && (n == 6 || n == 20);
        end while (!done_o && n < 4000);
        start = 1'b0;
        check({tag, " done timeout"}, n < 4000, 1);
        check({tag, " mask"}, dir_mask_o, emask);
        check({tag, " legal"}, legal_o, emask != 8'd0);
        check({tag, " writes"}, wr_log.size(), (emask != 8'd0) ? total + 1 : 0);
        bad = 0;
        for (int a = 0; a < 128; a++) if (mem[a] !== exp_b[a]) bad++;
        check({tag, " board cells wrong"}, bad, 0);
        check({tag, " loads"}, step_log.size(), 8);
        for (int i = 0; i < 8 && i < step_log.size(); i++)
            check({tag, " step"}, step_log[i], dir_tab[i]);
        if (emask != 8'd0 && wr_log.size() > 0)
            check({tag, " place"}, wr_log[wr_log.size() - 1], {7'(addr), me});
        check({tag, " ld/start overlap"}, overlap, 0);
`ifdef MOVE_SEQ_FLIP_COUNT_EN
        exp_fc = (total > 63) ? 63 : total;
`else
        exp_fc = 0;
`endif
        check({tag, " flip count"}, flip_count_o, exp_fc);
        @(negedge clock);
        check({tag, " done one cycle"}, done_o, 0);
    endtask

    task automatic two_dir_board();
        clear_board();
        board[44] = 2'b10;
        board[43] = 2'b10;
        board[42] = 2'b01;
        board[46] = 2'b10;
        board[47] = 2'b10;
        board[48] = 2'b01;
    endtask

    initial begin
        int n, addr;
        #2 reset = 1'b0;
        repeat (2) @(negedge clock);
        check("reset outputs", {ld_vali_o, start_vali_o, step_o, s_addr_o, ctrl_mem_o, mem_addr_o,
               mem_wren_o, mem_data_o, dir_mask_o, legal_o, done_o, flip_count_o}, 0);
        reset = 1'b1;
        @(negedge clock);

        clear_board();
        board[55] = 2'b10;
        board[65] = 2'b01;
        run_move(1'b0, 45, 1, 1'b0, 1'b0, "single");
        check("single mask exact", dir_mask_o, 8'b0100_0000);
        if (wr_log.size() >= 2) begin
            check("single flip wr", wr_log[0], {7'd55, 2'b01});
            check("single place wr", wr_log[1], {7'd45, 2'b01});
        end

        two_dir_board();
        run_move(1'b0, 45, 2, 1'b1, 1'b0, "allzero");

        two_dir_board();
        run_move(1'b0, 45, 1, 1'b0, 1'b0, "twodir");
        check("twodir mask exact", dir_mask_o, 8'b0001_1000);
        if (wr_log.size() >= 5) begin
            check("twodir wr0", wr_log[0], {7'd44, 2'b01});
            check("twodir wr1", wr_log[1], {7'd43, 2'b01});
            check("twodir wr2", wr_log[2], {7'd46, 2'b01});
            check("twodir wr3", wr_log[3], {7'd47, 2'b01});
        end

        run_move(1'b0, 45, 1, 1'b0, 1'b1, "glitch");
        run_move(1'b0, 45, 20, 1'b0, 1'b0, "delay20");

        for (int t = 0; t < 40; t++) begin
            clear_board();
            for (int a = 11; a < 89; a++)
                if (board[a] != 2'b11) board[a] = 2'($urandom_range(0, 2));
            addr = 10 * $urandom_range(1, 8) + $urandom_range(1, 8);
            board[addr] = 2'b00;
            run_move(1'($urandom_range(0, 1)), addr, $urandom_range(1, 4), 1'b0,
                     1'($urandom_range(0, 1)), "rand");
        end

        // Abort in the middle of a flip walk.
        two_dir_board();
        load_board();
        wr_log.delete();
        v_delay   = 1;
        v_zero    = 1'b0;
        player    = 1'b0;
        move_addr = 7'd45;
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (wr_log.size() < 1 && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("abort wait timeout", n < 500, 1);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("abort outputs", {ld_vali_o, start_vali_o, step_o, s_addr_o, ctrl_mem_o, mem_addr_o,
               mem_wren_o, mem_data_o, dir_mask_o, legal_o, done_o, flip_count_o}, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        n = 0;
        repeat (20) begin
            @(negedge clock);
            if (done_o || ld_vali_o) n++;
        end
        check("abort writes", wr_log.size(), 1);
        check("abort stays idle", n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
- Per-move controller for the Othello datapath; sits directly upstream of the per-direction validator.
- On start, sweeps all 8 directions from the candidate square: loads the validator with each step, launches it and collects the per-direction pass/fail into a mask.
- If any direction passes, it walks each passing direction, flips opponent discs to the mover's colour, then writes the placed disc.
- Reports done/legal to the main controller.

Parameters:
- BOARD_W, 10, padded row pitch in cells; border cells hold 2'b11.
- ADDR_W, 7, board-memory address width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse from main controller; ignored unless idle
- player  in  1  0 = black (2'b01), 1 = white (2'b10); sampled at start
- move_addr  in  7  candidate square; sampled at start
- s_done_in  in  1  validator finished current direction
- dir_status_in  in  1  validator verdict; valid while s_done_in = 1
- mem_data_in  in  2  board read data; synchronous RAM, 1-cycle latency
- ld_vali_o  out  1  validator load strobe
- start_vali_o  out  1  validator enable
- step_o  out  7  direction offset, modulo 128
- s_addr_o  out  7  start address for validator (= move_addr)
- ctrl_mem_o  out  1  1 = this block owns the memory port
- mem_addr_o  out  7  board address
- mem_wren_o  out  1  board write enable
- mem_data_o  out  2  board write data
- dir_mask_o  out  8  per-direction pass mask, bit i = direction i
- legal_o  out  1  move legal; valid with done_o
- done_o  out  1  one-cycle completion pulse
- flip_count_o  out  6  discs flipped (see Optional Feature)

Behaviour:
- Reset (async, reset = 0): state IDLE; all outputs 0; dir_mask_o = 0; direction index = 0. Reset asserted mid-sweep or mid-flip aborts immediately; no further memory writes.
- Direction table, index 0..7, 7-bit mod-128 offsets:
  - -(W+1), -W, -(W-1), -1, +1, W-1, W, W+1, with W = BOARD_W.
  - Default values: 117, 118, 119, 127, 1, 9, 10, 11.
- IDLE: on start, latch player/move_addr, clear mask and index, go LOAD.
- LOAD (1 cycle): ld_vali_o = 1, step_o = table[index]; go LAUNCH.
- LAUNCH: start_vali_o = 1; held until s_done_in; go WAIT.
- WAIT: on s_done_in, mask[index] <= dir_status_in; drop start_vali_o.
  - If index = 7, go DECIDE; else index + 1, go LOAD.
  - ctrl_mem_o = 0 throughout the sweep; the validator owns memory.
- DECIDE:
  - mask = 0: legal_o = 0, done_o pulse, go IDLE; no writes.
  - Otherwise: index <= lowest set bit, cursor <= move_addr + step, go FRD.
- FRD: ctrl_mem_o = 1, mem_addr_o = cursor, wren 0; go FCHK after 1 cycle (RAM latency).
- FCHK: examine mem_data_in.
  - Opponent colour: write mover colour at cursor (1 cycle, wren 1), cursor += step, go FRD.
  - Any other value: direction complete; advance to next set mask bit, or PLACE if none.
- PLACE (1 cycle): write mover colour at move_addr; go DONE.
- DONE: legal_o = 1, done_o = 1 for one cycle, ctrl_mem_o = 0; go IDLE.
- legal_o and dir_mask_o hold until the next start.
- Address arithmetic wraps mod 128.
- Flip walk for one direction is bounded at 7 cells; a walk past this limit forces direction completion (defensive).
- start while not IDLE: ignored.
- s_done_in outside WAIT: ignored.
- ld_vali_o and start_vali_o are never high in the same cycle.

Optional Feature:
- MOVE_SEQ_FLIP_COUNT_EN defined: 6-bit counter cleared at start, +1 per flip write, saturates at 63, stable from done_o until the next start.
- Undefined: flip_count_o tied to 0 and no counter logic is built.

Test Plan:
- Reset mid-flip (reset low during FCHK) -> all outputs 0 next edge, no further wren, state IDLE.
- Black at 45 with only white at 55 and black at 65 (step 10) -> mask 8'b0100_0000; one write (55 <= 01), then 45 <= 01; legal_o = 1; flip_count_o = 1 if enabled.
- Candidate with validator returning 0 for all 8 directions -> 8 LOAD/LAUNCH pairs with steps 117,118,119,127,1,9,10,11; done_o with legal_o = 0; zero writes.
- Two passing directions (mask bits 3 and 4), two flips each -> directions walked in index order; 4 flip writes then place; flip_count_o = 4.
- start pulsed during sweep -> ignored; mask and step sequence unchanged.
- Validator s_done_in delayed 20 cycles -> start_vali_o held high 20 cycles; no extra direction consumed.
